// File: rtl/mux2_arb_pkg.sv
// Shared types and constants for the two-input round-robin arbiter in front of the 2:1 data mux.
package mux2_arb_pkg;

    typedef logic sel_t;

    localparam sel_t SEL_IN0        = 1'b0;
    localparam sel_t SEL_IN1        = 1'b1;
    localparam sel_t RST_LAST_GRANT = SEL_IN1;

    // Round-robin successor: on contention the source that did not win last time goes next.
    function automatic sel_t rr_next(input sel_t last_grant);
        return sel_t'(~last_grant);
    endfunction

endpackage

// File: rtl/mux2_arb_grant.sv
// Combinational grant decision for two requesters with round-robin tie-break and optional packet lock.
module mux2_arb_grant
    import mux2_arb_pkg::*;
(
    input  logic in0_valid,
    input  logic in1_valid,
    input  sel_t last_grant,
    input  logic lock,
    output sel_t grant,
    output logic any_valid
);

    // Pick a source; while a packet is open the previous winner keeps the mux.
    always_comb begin
        grant     = SEL_IN0;
        any_valid = 1'b0;
        if (lock) begin
            grant     = last_grant;
            any_valid = (last_grant == SEL_IN1) ? in1_valid : in0_valid;
        end else begin
            case ({in1_valid, in0_valid})
                2'b11: begin
                    grant     = rr_next(last_grant);
                    any_valid = 1'b1;
                end
                2'b01: begin
                    grant     = SEL_IN0;
                    any_valid = 1'b1;
                end
                2'b10: begin
                    grant     = SEL_IN1;
                    any_valid = 1'b1;
                end
                default: begin
                    grant     = SEL_IN0;
                    any_valid = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/mux2_rr_arbiter.sv
// Round-robin arbiter for two valid/ready streams feeding a registered one-entry output stage with select.
// Optional packet locking (in*_last / out_last) is enabled by defining MUX2_ARB_PKT_LOCK_EN.
module mux2_rr_arbiter
    import mux2_arb_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in0_valid,
    output logic             in0_ready,
    input  logic [WIDTH-1:0] in0_data,
    input  logic             in1_valid,
    output logic             in1_ready,
    input  logic [WIDTH-1:0] in1_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
`ifdef MUX2_ARB_PKT_LOCK_EN
    input  logic             in0_last,
    input  logic             in1_last,
    output logic             out_last,
`endif
    output logic             out_sel
);

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q,  out_data_d;
    sel_t             out_sel_q,   out_sel_d;
    sel_t             last_grant_q, last_grant_d;
    logic             load_s;
    logic             xfer_s;
    logic             lock_s;
    logic             any_valid_s;
    sel_t             grant_s;

`ifdef MUX2_ARB_PKT_LOCK_EN
    logic             out_last_q, out_last_d;
    logic             lock_q,     lock_d;
    logic             grant_last_s;

    assign lock_s       = lock_q;
    assign grant_last_s = (grant_s == SEL_IN1) ? in1_last : in0_last;
    assign out_last     = out_last_q;
`else
    assign lock_s = 1'b0;
`endif

    mux2_arb_grant u_grant (
        .in0_valid  (in0_valid),
        .in1_valid  (in1_valid),
        .last_grant (last_grant_q),
        .lock       (lock_s),
        .grant      (grant_s),
        .any_valid  (any_valid_s)
    );

    // The output stage can take a new beat when empty or being drained this cycle.
    assign load_s    = !out_valid_q || out_ready;
    assign xfer_s    = load_s && any_valid_s;
    assign in0_ready = load_s && in0_valid && (grant_s == SEL_IN0);
    assign in1_ready = load_s && in1_valid && (grant_s == SEL_IN1);

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;

    // Next-state for the output register, round-robin pointer and packet lock.
    always_comb begin
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_sel_d    = out_sel_q;
        last_grant_d = last_grant_q;
`ifdef MUX2_ARB_PKT_LOCK_EN
        out_last_d   = out_last_q;
        lock_d       = lock_q;
`endif
        if (xfer_s) begin
            out_valid_d  = 1'b1;
            out_data_d   = (grant_s == SEL_IN1) ? in1_data : in0_data;
            out_sel_d    = grant_s;
            last_grant_d = grant_s;
`ifdef MUX2_ARB_PKT_LOCK_EN
            out_last_d   = grant_last_s;
            lock_d       = !grant_last_s;
`endif
        end else if (load_s) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // State registers with synchronous reset; a reset drops any held beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= {WIDTH{1'b0}};
            out_sel_q    <= SEL_IN0;
            last_grant_q <= RST_LAST_GRANT;
`ifdef MUX2_ARB_PKT_LOCK_EN
            out_last_q   <= 1'b0;
            lock_q       <= 1'b0;
`endif
        end else begin
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_sel_q    <= out_sel_d;
            last_grant_q <= last_grant_d;
`ifdef MUX2_ARB_PKT_LOCK_EN
            out_last_q   <= out_last_d;
            lock_q       <= lock_d;
`endif
        end
    end

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Directed scoreboard bench for mux2_rr_arbiter; expected output beats are queued by stimulus and popped by a monitor.
module tb_mux2_rr_arbiter;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             in0_valid, in1_valid, out_ready;
    logic [WIDTH-1:0] in0_data, in1_data;
    logic             in0_ready, in1_ready, out_valid, out_sel;
    logic [WIDTH-1:0] out_data;
`ifdef MUX2_ARB_PKT_LOCK_EN
    logic             in0_last, in1_last, out_last;
`endif

    typedef struct packed {
        logic             sel;
        logic [WIDTH-1:0] data;
        logic             last;
    } exp_t;

    exp_t exp_q[$];
    int   compared   = 0;
    int   mismatched = 0;

    mux2_rr_arbiter #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in0_valid (in0_valid),
        .in0_ready (in0_ready),
        .in0_data  (in0_data),
        .in1_valid (in1_valid),
        .in1_ready (in1_ready),
        .in1_data  (in1_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
`ifdef MUX2_ARB_PKT_LOCK_EN
        .in0_last  (in0_last),
        .in1_last  (in1_last),
        .out_last  (out_last),
`endif
        .out_sel   (out_sel)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic sel, input logic [WIDTH-1:0] data, input logic last);
        exp_t e;
        e.sel  = sel;
        e.data = data;
        e.last = last;
        exp_q.push_back(e);
    endtask

    // Monitor: every beat accepted downstream must match the next queued expectation.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL unexpected_beat: got sel=%0d data=0x%0h, required no beat", out_sel, out_data);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("beat_sel", {31'd0, out_sel}, {31'd0, e.sel});
                chk("beat_data", {24'd0, out_data}, {24'd0, e.data});
`ifdef MUX2_ARB_PKT_LOCK_EN
                chk("beat_last", {31'd0, out_last}, {31'd0, e.last});
`endif
            end
        end
    end

    // Both sources offer beats each cycle; exp_g bit i is the grant required in cycle i.
    task automatic run_stream(input int ncyc, input logic [7:0] exp_g, input int in1_max,
                              input int pkt_len, input logic [WIDTH-1:0] base0,
                              input logic [WIDTH-1:0] base1);
        int c0 = 0;
        int c1 = 0;
        for (int i = 0; i < ncyc; i++) begin
            in0_valid = 1'b1;
            in0_data  = base0 + WIDTH'(c0);
            in1_valid = (c1 < in1_max);
            in1_data  = base1 + WIDTH'(c1);
`ifdef MUX2_ARB_PKT_LOCK_EN
            in0_last  = 1'b1;
            in1_last  = (pkt_len == 0) || (c1 == pkt_len - 1);
`endif
            #1;
            chk("in0_ready", {31'd0, in0_ready}, {31'd0, ~exp_g[i]});
            chk("in1_ready", {31'd0, in1_ready}, {31'd0, exp_g[i]});
            if (in0_ready) c0++;
            if (in1_ready) c1++;
            step();
        end
        in0_valid = 1'b0;
        in1_valid = 1'b0;
    endtask

    initial begin
        logic [7:0] g;
        rst = 1'b1; in0_valid = 1'b0; in1_valid = 1'b0; out_ready = 1'b1;
        in0_data = '0; in1_data = '0;
`ifdef MUX2_ARB_PKT_LOCK_EN
        in0_last = 1'b1; in1_last = 1'b1;
`endif
        step(); step();
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_data", {24'd0, out_data}, 32'd0);
        chk("rst_out_sel", {31'd0, out_sel}, 32'd0);

        // 1: single beat from in0
        rst = 1'b0;
        push(1'b0, 8'h11, 1'b1);
        in0_valid = 1'b1; in0_data = 8'h11;
        #1;
        chk("t1_in0_ready", {31'd0, in0_ready}, 32'd1);
        step();
        in0_valid = 1'b0;
        chk("t1_out_valid", {31'd0, out_valid}, 32'd1);
        chk("t1_out_data", {24'd0, out_data}, 32'h11);
        chk("t1_out_sel", {31'd0, out_sel}, 32'd0);
        step();
        chk("t1_drained", {31'd0, out_valid}, 32'd0);

        // 2: continuous contention after a fresh reset alternates 0,1,0,1
        rst = 1'b1; step(); rst = 1'b0;
        push(1'b0, 8'hA0, 1'b1); push(1'b1, 8'hB0, 1'b1);
        push(1'b0, 8'hA1, 1'b1); push(1'b1, 8'hB1, 1'b1);
        push(1'b0, 8'hA2, 1'b1); push(1'b1, 8'hB2, 1'b1);
        g = 8'b0010_1010;
        run_stream(6, g, 99, 0, 8'hA0, 8'hB0);
        step();
        chk("t2_drained", {31'd0, out_valid}, 32'd0);

        // 3: downstream stall holds the beat, then reload without a bubble
        push(1'b0, 8'h31, 1'b1); push(1'b1, 8'h41, 1'b1); push(1'b0, 8'h32, 1'b1);
        out_ready = 1'b0;
        in0_valid = 1'b1; in0_data = 8'h31;
        in1_valid = 1'b1; in1_data = 8'h41;
        #1;
        chk("t3_in0_ready", {31'd0, in0_ready}, 32'd1);
        step();
        in0_data = 8'h32;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t3_stall_rdy", {30'd0, in1_ready, in0_ready}, 32'd0);
            chk("t3_stall_data", {24'd0, out_data}, 32'h31);
            chk("t3_stall_sel", {31'd0, out_sel}, 32'd0);
            chk("t3_stall_valid", {31'd0, out_valid}, 32'd1);
            step();
        end
        out_ready = 1'b1;
        #1;
        chk("t3_release_rdy", {30'd0, in1_ready, in0_ready}, 32'd2);
        step();
        chk("t3_nobubble_valid", {31'd0, out_valid}, 32'd1);
        chk("t3_nobubble_data", {24'd0, out_data}, 32'h41);
        in1_valid = 1'b0;
        #1;
        chk("t3_in0_ready2", {31'd0, in0_ready}, 32'd1);
        step();
        in0_valid = 1'b0;
        step();

        // 4: reset while a beat is stalled drops it and restores the pointer
        out_ready = 1'b0;
        in0_valid = 1'b1; in0_data = 8'h51;
        step();
        in0_valid = 1'b0;
        chk("t4_held", {31'd0, out_valid}, 32'd1);
        rst = 1'b1;
        step();
        chk("t4_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("t4_rst_data", {24'd0, out_data}, 32'd0);
        rst = 1'b0; out_ready = 1'b1;
        push(1'b0, 8'h61, 1'b1); push(1'b1, 8'h71, 1'b1);
        g = 8'b0000_0010;
        run_stream(2, g, 99, 0, 8'h61, 8'h71);
        step();

        // 5: packet from in1 against busy in0; one in0 beat first leaves the pointer at 0
        push(1'b0, 8'h90, 1'b1);
        in0_valid = 1'b1; in0_data = 8'h90;
        step();
        in0_valid = 1'b0;
        step();
`ifdef MUX2_ARB_PKT_LOCK_EN
        push(1'b1, 8'hB0, 1'b0); push(1'b1, 8'hB1, 1'b0);
        push(1'b1, 8'hB2, 1'b1); push(1'b0, 8'hA0, 1'b1);
        g = 8'b0000_0111;
`else
        push(1'b1, 8'hB0, 1'b0); push(1'b0, 8'hA0, 1'b1);
        push(1'b1, 8'hB1, 1'b0); push(1'b0, 8'hA1, 1'b1);
        g = 8'b0000_0101;
`endif
        run_stream(4, g, 3, 3, 8'hA0, 8'hB0);
        step(); step();

        chk("queue_empty", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
